// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Shares the single board I2C bus between several independent I2C masters
// (ADV7513 init, ADV7513 register read, camera configuration). One requester
// at a time owns the bus through a req/grant/done handshake. The owner's
// open-drain pull-low enables are forwarded to the pad logic. Every ownership
// is followed by an idle gap with both lines released. A grant that lasts
// too long is revoked and flagged.
//
// Optional feature macro: ARB_FIXED_PRIORITY_EN
//   undefined (default) : round-robin arbitration starting after the last owner
//   defined             : lowest eligible index wins; rr pointer frozen
//
// Ports:
//   clk          in   system clock (50 MHz)
//   reset        in   synchronous, active-high reset
//   req          in   [NUM_REQ] per-requester bus request (level)
//   done         in   [NUM_REQ] per-requester transaction-complete pulse
//   scl_pull_in  in   [NUM_REQ] per-requester SCL drive-low enable
//   sda_pull_in  in   [NUM_REQ] per-requester SDA drive-low enable
//   grant        out  [NUM_REQ] one-hot ownership, zero when no owner
//   busy         out  high whenever the arbiter is not idle
//   owner        out  [ID_BITS] index of current or last owner
//   scl_pull     out  SCL pad drive-low enable
//   sda_pull     out  SDA pad drive-low enable
//   timeout_err  out  sticky timeout flag, cleared only by reset
//   timeout_id   out  [ID_BITS] index of the requester that last timed out
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
    parameter int          NUM_REQ        = 3,
    parameter int          ID_BITS        = 2,
    parameter logic [15:0] GAP_CYCLES     = 16'd100,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    input  logic [NUM_REQ-1:0] scl_pull_in,
    input  logic [NUM_REQ-1:0] sda_pull_in,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic [ID_BITS-1:0] owner,
    output logic               scl_pull,
    output logic               sda_pull,
    output logic               timeout_err,
    output logic [ID_BITS-1:0] timeout_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [ID_BITS-1:0] RR_INIT   = ID_BITS'(NUM_REQ - 1);
    localparam logic [15:0]        GAP_LAST  = GAP_CYCLES - 16'd1;
    localparam logic [31:0]        TCNT_LAST = TIMEOUT_CYCLES - 32'd1;

    state_t               state_reg, state_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic                 busy_reg, busy_next;
    logic [ID_BITS-1:0]   owner_reg, owner_next;
    logic                 scl_reg, scl_next;
    logic                 sda_reg, sda_next;
    logic                 terr_reg, terr_next;
    logic [ID_BITS-1:0]   tid_reg, tid_next;
    logic [ID_BITS-1:0]   rr_reg, rr_next;
    logic [15:0]          gcnt_reg, gcnt_next;
    logic [31:0]          tcnt_reg, tcnt_next;
    logic [NUM_REQ-1:0]   mask_reg, mask_next;

    // A requester that timed out stays masked until it drops req.
    logic [NUM_REQ-1:0]   eligible;
    assign eligible = req & ~mask_reg;

    // -----------------------------------------------------------------------
    // Winner selection
    // -----------------------------------------------------------------------
    logic                 win_found;
    logic [ID_BITS-1:0]   win_id;

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        // Scan from the top so the lowest eligible index is the last write.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_found = 1'b1;
                win_id    = ID_BITS'(i);
            end
        end
    end
`else
    int rr_dist;
    int rr_best;

    // Each candidate gets its distance after the rr pointer (0 = the index
    // right after the last owner); the smallest distance wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        rr_dist   = 0;
        rr_best   = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_dist = (i + NUM_REQ - 1 - int'(rr_reg)) % NUM_REQ;
            if (eligible[i] && (rr_dist < rr_best)) begin
                rr_best   = rr_dist;
                win_found = 1'b1;
                win_id    = ID_BITS'(i);
            end
        end
    end
`endif

    logic [NUM_REQ-1:0] win_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign win_onehot[gi] = win_found && (win_id == ID_BITS'(gi));
        end
    endgenerate

    // grant_reg is one-hot on the owner while in S_GRANT, so AND-reducing
    // against it selects the owner's inputs and ignores everyone else.
    logic done_own;
    logic req_own;
    logic scl_sel;
    logic sda_sel;
    logic tcnt_end;

    assign done_own = |(done & grant_reg);
    assign req_own  = |(req & grant_reg);
    assign scl_sel  = |(scl_pull_in & grant_reg);
    assign sda_sel  = |(sda_pull_in & grant_reg);
    assign tcnt_end = (tcnt_reg == TCNT_LAST);

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            owner_reg <= '0;
            scl_reg   <= 1'b0;
            sda_reg   <= 1'b0;
            terr_reg  <= 1'b0;
            tid_reg   <= '0;
            rr_reg    <= RR_INIT;
            gcnt_reg  <= '0;
            tcnt_reg  <= '0;
            mask_reg  <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            busy_reg  <= busy_next;
            owner_reg <= owner_next;
            scl_reg   <= scl_next;
            sda_reg   <= sda_next;
            terr_reg  <= terr_next;
            tid_reg   <= tid_next;
            rr_reg    <= rr_next;
            gcnt_reg  <= gcnt_next;
            tcnt_reg  <= tcnt_next;
            mask_reg  <= mask_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        owner_next = owner_reg;
        scl_next   = 1'b0;
        sda_next   = 1'b0;
        terr_next  = terr_reg;
        tid_next   = tid_reg;
        rr_next    = rr_reg;
        gcnt_next  = gcnt_reg;
        tcnt_next  = tcnt_reg;
        // Any cycle with req low unmasks that requester.
        mask_next  = mask_reg & req;

        case (state_reg)
            S_IDLE: begin
                if (win_found) begin
                    owner_next = win_id;
                    grant_next = win_onehot;
                    tcnt_next  = '0;
                    state_next = S_GRANT;
                end
            end

            S_GRANT: begin
                tcnt_next = tcnt_reg + 32'd1;
                scl_next  = scl_sel;
                sda_next  = sda_sel;
                // done and abandon both take precedence over the timeout.
                if (done_own || !req_own || tcnt_end) begin
                    if (!done_own && req_own) begin
                        terr_next = 1'b1;
                        tid_next  = owner_reg;
                        mask_next = (mask_reg & req) | grant_reg;
                    end
                    grant_next = '0;
                    scl_next   = 1'b0;
                    sda_next   = 1'b0;
                    gcnt_next  = '0;
`ifndef ARB_FIXED_PRIORITY_EN
                    rr_next    = owner_reg;
`endif
                    state_next = S_GAP;
                end
            end

            S_GAP: begin
                gcnt_next = gcnt_reg + 16'd1;
                if (gcnt_reg == GAP_LAST) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                grant_next = '0;
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    assign grant       = grant_reg;
    assign busy        = busy_reg;
    assign owner       = owner_reg;
    assign scl_pull    = scl_reg;
    assign sda_pull    = sda_reg;
    assign timeout_err = terr_reg;
    assign timeout_id  = tid_reg;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_arbiter
//
// Scoreboard bench. Each round raises a set of requests; the reference model
// predicts the grant order and the timeout flags from the arbitration rules
// and pushes one entry per ownership. A monitor pops entries when grants
// start/end and also checks pad multiplexing, one-hot grant and gap length.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_bus_arbiter;

    localparam int N   = 3;
    localparam int IDB = 2;
    localparam int GAP = 4;
    localparam int TO  = 50;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   done = '0;
    logic [N-1:0]   scl_in = '0;
    logic [N-1:0]   sda_in = '0;
    logic [N-1:0]   grant;
    logic           busy;
    logic [IDB-1:0] owner;
    logic           scl_pull;
    logic           sda_pull;
    logic           timeout_err;
    logic [IDB-1:0] timeout_id;

    i2c_bus_arbiter #(
        .NUM_REQ        (N),
        .ID_BITS        (IDB),
        .GAP_CYCLES     (16'(GAP)),
        .TIMEOUT_CYCLES (32'(TO))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .scl_pull_in (scl_in),
        .sda_pull_in (sda_in),
        .grant       (grant),
        .busy        (busy),
        .owner       (owner),
        .scl_pull    (scl_pull),
        .sda_pull    (sda_pull),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int id;
        bit terr;
        int tid;
        bit to;
    } exp_t;

    exp_t sb[$];
    int   m_rr   = N - 1;
    bit   m_terr = 1'b0;
    int   m_tid  = 0;
    int   plan_act [N];   // 0 = done, 1 = abandon, 2 = timeout
    int   plan_dly [N];

    function automatic int pick(input logic [N-1:0] pend, input int rr);
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < N; i++) if (pend[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (pend[(rr + k) % N]) return (rr + k) % N;
`endif
        return 0;
    endfunction

    task automatic push_exp(input int id, input bit to);
        exp_t e;
        if (to) begin
            m_terr = 1'b1;
            m_tid  = id;
        end
        e.id = id; e.terr = m_terr; e.tid = m_tid; e.to = to;
        sb.push_back(e);
`ifndef ARB_FIXED_PRIORITY_EN
        m_rr = id;
`endif
    endtask

    // ---------------- monitor ----------------
    bit           mon_en   = 1'b0;
    bit           pad_rand = 1'b0;
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] prev_scl = '0;
    logic [N-1:0] prev_sda = '0;
    int           glen = 0;
    int           gap_cnt = 0;
    bit           in_gap = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            check("scl_mux", 32'(scl_pull), 32'(|(prev_scl & prev_grant & grant)));
            check("sda_mux", 32'(sda_pull), 32'(|(prev_sda & prev_grant & grant)));
            if (prev_grant == '0 && grant != '0) begin
                check("idle_before_grant", 32'(in_gap), 32'd0);
                in_gap = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_grant", 32'(grant), 32'd0);
                end else begin
                    $display("grant start: grant=%b owner=%0d expected_id=%0d", grant, owner, sb[0].id);
                    check("grant", 32'(grant), 32'(1 << sb[0].id));
                    check("owner", 32'(owner), 32'(sb[0].id));
                    check("busy_in_grant", 32'(busy), 32'd1);
                end
                glen = 1;
            end else if (prev_grant != '0 && grant != '0) begin
                check("grant_stable", 32'(grant), 32'(prev_grant));
                glen++;
            end else if (prev_grant != '0 && grant == '0) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    $display("grant end: id=%0d len=%0d terr=%0b tid=%0d", e.id, glen, timeout_err, timeout_id);
                    check("timeout_err", 32'(timeout_err), 32'(e.terr));
                    check("timeout_id", 32'(timeout_id), 32'(e.tid));
                    if (e.to) check("timeout_len", 32'(glen), 32'(TO));
                end
                in_gap  = 1'b1;
                gap_cnt = busy ? 1 : 0;
            end else if (in_gap) begin
                if (busy) gap_cnt++;
                else begin
                    check("gap_len", 32'(gap_cnt), 32'(GAP));
                    in_gap = 1'b0;
                end
            end
        end
        prev_grant = grant;
        prev_scl   = scl_in;
        prev_sda   = sda_in;
    end

    // Random pad activity from every requester, owner or not.
    always @(posedge clk) begin
        if (pad_rand) begin
            #1;
            scl_in = 3'($urandom);
            sda_in = 3'($urandom);
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output bit ok, output int gid, output int n);
        ok = 1'b0; gid = 0; n = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            n++;
            if (grant != '0) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_grant: no grant within 300 cycles");
        end else begin
            for (int i = 0; i < N; i++) if (grant[i]) gid = i;
        end
    endtask

    task automatic wait_release();
        bit ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (grant == '0) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_release: grant held over 300 cycles");
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_idle: busy over 300 cycles");
        end
    endtask

    task automatic serve(input int id, input int act, input int dly);
        logic [N-1:0] own;
        own = N'(1 << id);
        case (act)
            0: begin
                repeat (dly + 1) @(posedge clk);
                #1;
                // Stray done pulses from non-owners ride along.
                done = own | (3'($urandom) & ~own);
                tick();
                done    = '0;
                req[id] = 1'b0;
            end
            1: begin
                repeat (dly + 1) @(posedge clk);
                #1;
                req[id] = 1'b0;
            end
            default: begin
                wait_release();
                tick();
                req[id] = 1'b0;
            end
        endcase
    endtask

    task automatic run_round(input logic [N-1:0] set);
        logic [N-1:0] pend;
        bit ok;
        int gid, n, cnt, id;
        pend = set;
        cnt  = 0;
        wait_idle();
        while (pend != '0) begin
            id = pick(pend, m_rr);
            push_exp(id, plan_act[id] == 2);
            pend[id] = 1'b0;
            cnt++;
        end
        tick();
        req = set;
        for (int k = 0; k < cnt; k++) begin
            wait_grant(ok, gid, n);
            if (!ok) return;
            if (k == 0) check("req_to_grant_latency", 32'(n - 1), 32'd1);
            serve(gid, plan_act[gid], plan_dly[gid]);
            if (plan_act[gid] != 2) wait_release();
        end
    endtask

    task automatic plan_all(input int act, input int dly);
        for (int i = 0; i < N; i++) begin
            plan_act[i] = act;
            plan_dly[i] = dly;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int gid, n, w;

        repeat (2) tick();
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_scl", 32'(scl_pull), 32'd0);
        check("rst_sda", 32'(sda_pull), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_tid", 32'(timeout_id), 32'd0);
        tick();
        reset    = 1'b0;
        mon_en   = 1'b1;
        pad_rand = 1'b1;

        // Single request, done 40 clk after grant.
        plan_all(0, 5);
        plan_dly[1] = 39;
        run_round(3'b010);

        // Fairness with all three requesting.
        plan_all(0, 3);
        run_round(3'b111);
        run_round(3'b111);

        // Owner abandons; the other requester follows after the gap.
        plan_all(1, 7);
        run_round(3'b011);

        // done on the timeout terminal cycle: done wins, no error.
        plan_all(0, TO - 2);
        run_round(3'b100);
        check("simul_done_timeout_terr", 32'(timeout_err), 32'd0);

        // Timeout with req held: masked until dropped and re-raised.
        wait_idle();
        push_exp(2, 1'b1);
        tick();
        req = 3'b100;
        wait_grant(ok, gid, n);
        wait_release();
        repeat (20) @(negedge clk);
        check("masked_no_regrant", 32'(grant), 32'd0);
        check("masked_idle", 32'(busy), 32'd0);
        tick();
        req = 3'b000;
        tick();
        req = 3'b100;
        push_exp(2, 1'b0);
        wait_grant(ok, gid, n);
        check("regrant_latency", 32'(n - 1), 32'd1);
        if (ok) serve(2, 0, 5);
        wait_release();

        // Randomised rounds.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                w = int'($urandom_range(0, 9));
                plan_act[i] = (w < 7) ? 0 : ((w < 9) ? 1 : 2);
                plan_dly[i] = int'($urandom_range(0, 30));
            end
            run_round(3'($urandom_range(1, 7)));
        end
        wait_idle();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Reset in the middle of a grant with SCL pulled.
        pad_rand = 1'b0;
        mon_en   = 1'b0;
        tick();
        scl_in = 3'b001;
        sda_in = 3'b000;
        req    = 3'b001;
        wait_grant(ok, gid, n);
        repeat (2) @(negedge clk);
        check("pre_reset_scl", 32'(scl_pull), 32'd1);
        tick();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_scl", 32'(scl_pull), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_terr", 32'(timeout_err), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("postrst_no_grant_yet", 32'(grant), 32'd0);
        @(negedge clk);
        check("postrst_grant", 32'(grant), 32'd1);
        check("postrst_owner", 32'(owner), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
